// File: rtl/sigma_rgbd_multi_generator_pkg.sv
// Shared RGB-D VO configuration: sigma generator defaults and FSM state encoding.
package RgbdVoConfigPk;

    localparam int SIGMA_NUM_CH      = 4;
    localparam int SIGMA_H_SIZE_BW   = 10;
    localparam int SIGMA_V_SIZE_BW   = 10;
    localparam int SIGMA_DATA_RGB_BW = 8;
    localparam int SIGMA_SUM_BW      = SIGMA_H_SIZE_BW + SIGMA_V_SIZE_BW + 2*SIGMA_DATA_RGB_BW + 2;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        SQRT,
        WRITE,
        DONE
    } sigma_state_t;

    function automatic int sigma_idx_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sigma_rgbd_multi_generator_serial_root.sv
// Bit-serial non-restoring integer square root, two radicand bits per cycle.
// Load on i_start; o_done pulses the cycle o_root becomes valid (ROOT_BW cycles later).
module sigma_serial_root #(
    parameter int ROOT_BW = 19
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [2*ROOT_BW-1:0] i_radicand,
    output logic                 o_done,
    output logic [ROOT_BW-1:0]   o_root
);

    localparam int RAD_BW  = 2*ROOT_BW;
    localparam int REM_BW  = ROOT_BW + 3;
    localparam int STEP_BW = $clog2(ROOT_BW + 1);
    localparam logic [STEP_BW-1:0] STEP_LAST = STEP_BW'(ROOT_BW - 1);

    logic [RAD_BW-1:0]  rad_q, rad_d;
    logic [REM_BW-1:0]  rem_q, rem_d;
    logic [ROOT_BW-1:0] root_q, root_d;
    logic [STEP_BW-1:0] step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [REM_BW-1:0]  rem_sh;
    logic [REM_BW-1:0]  trial;
    logic [REM_BW-1:0]  rem_step;

    always_comb begin
        rem_sh   = {rem_q[REM_BW-3:0], rad_q[RAD_BW-1 -: 2]};
        // Subtract {root,01} after a non-negative remainder, add {root,11} after a negative one.
        trial    = REM_BW'({root_q, rem_q[REM_BW-1], 1'b1});
        rem_step = rem_q[REM_BW-1] ? (rem_sh + trial) : (rem_sh - trial);

        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (i_start) begin
            rad_d  = i_radicand;
            rem_d  = '0;
            root_d = '0;
            step_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rad_d  = {rad_q[RAD_BW-3:0], 2'b00};
            rem_d  = rem_step;
            root_d = {root_q[ROOT_BW-2:0], ~rem_step[REM_BW-1]};
            step_d = step_q + STEP_BW'(1);
            if (step_q == STEP_LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_root = root_q;

endmodule

// File: rtl/sigma_rgbd_multi_generator.sv
// Per-frame multi-channel sigma = floor(sqrt(floor(sum_sq/count))) using one shared serial
// divider and root engine. Optional SIGMA_RGBD_FLOOR_EN clamps results up to MIN_SIGMA.
module sigma_rgbd_multi_generator
    import RgbdVoConfigPk::*;
#(
    parameter int NUM_CH      = SIGMA_NUM_CH,
    parameter int H_SIZE_BW   = SIGMA_H_SIZE_BW,
    parameter int V_SIZE_BW   = SIGMA_V_SIZE_BW,
    parameter int DATA_RGB_BW = SIGMA_DATA_RGB_BW,
    parameter int SUM_BW      = H_SIZE_BW + V_SIZE_BW + 2*DATA_RGB_BW + 2,
    parameter int CNT_BW      = H_SIZE_BW + V_SIZE_BW,
    parameter int OUT_BW      = DATA_RGB_BW + 1,
    parameter int MIN_SIGMA   = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_frame_end,
    input  logic [NUM_CH-1:0][SUM_BW-1:0]  i_sigma_s,
    input  logic [CNT_BW-1:0]              i_corresp_count,
    output logic                           o_busy,
    output logic                           o_drop,
    output logic                           o_frame_end,
    output logic [NUM_CH-1:0][OUT_BW-1:0]  o_sigma
);

    localparam int ROOT_BW = (SUM_BW + 1) / 2;
    localparam int RAD_BW  = 2*ROOT_BW;
    localparam int CH_BW   = sigma_idx_bw(NUM_CH);
    localparam int CYC_BW  = $clog2(SUM_BW + 1);
    localparam int EXT_BW  = ROOT_BW + OUT_BW;
    localparam int REM_BW  = CNT_BW + 1;

    localparam logic [CYC_BW-1:0] DIV_LAST  = CYC_BW'(SUM_BW - 1);
    localparam logic [CYC_BW-1:0] SQRT_LAST = CYC_BW'(ROOT_BW - 1);
    localparam logic [CH_BW-1:0]  CH_LAST   = CH_BW'(NUM_CH - 1);

    sigma_state_t                  state_q, state_d;
    logic [CH_BW-1:0]              ch_q, ch_d;
    logic [CYC_BW-1:0]             cyc_q, cyc_d;
    logic [SUM_BW-1:0]             quo_q, quo_d;
    logic [REM_BW-1:0]             rem_q, rem_d;
    logic [CNT_BW-1:0]             count_q, count_d;
    logic [NUM_CH-1:0][SUM_BW-1:0] sum_q, sum_d;
    logic [NUM_CH-1:0][OUT_BW-1:0] sigma_q, sigma_d;
    logic                          busy_q, busy_d;
    logic                          drop_q, drop_d;
    logic                          fend_q, fend_d;

    logic [REM_BW:0]     rem_sh;
    logic [REM_BW:0]     count_ext;
    logic                q_bit;
    logic [SUM_BW-1:0]   quo_step;
    logic                root_start;
    logic                root_done;
    logic [ROOT_BW-1:0]  root;
    logic [EXT_BW-1:0]   root_ext;
    logic [OUT_BW-1:0]   sat_val;
    logic [OUT_BW-1:0]   wr_val;
    logic [CH_BW-1:0]    ch_next;

    sigma_serial_root #(
        .ROOT_BW    (ROOT_BW)
    ) u_root (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (root_start),
        .i_radicand (RAD_BW'(quo_step)),
        .o_done     (root_done),
        .o_root     (root)
    );

    always_comb begin
        // Restoring divide step; a zero count never sets a quotient bit, forcing quotient 0.
        rem_sh    = {rem_q, quo_q[SUM_BW-1]};
        count_ext = (REM_BW+1)'(count_q);
        q_bit     = (count_q != '0) && (rem_sh >= count_ext);
        quo_step  = {quo_q[SUM_BW-2:0], q_bit};

        root_ext = EXT_BW'(root);
        sat_val  = (|root_ext[EXT_BW-1:OUT_BW]) ? '1 : root_ext[OUT_BW-1:0];
`ifdef SIGMA_RGBD_FLOOR_EN
        wr_val   = (sat_val < OUT_BW'(MIN_SIGMA)) ? OUT_BW'(MIN_SIGMA) : sat_val;
`else
        wr_val   = sat_val;
`endif
        ch_next  = ch_q + CH_BW'(1);

        state_d    = state_q;
        ch_d       = ch_q;
        cyc_d      = cyc_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        count_d    = count_q;
        sum_d      = sum_q;
        sigma_d    = sigma_q;
        busy_d     = busy_q;
        drop_d     = i_frame_end && (state_q != IDLE);
        fend_d     = 1'b0;
        root_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_frame_end) begin
                    sum_d   = i_sigma_s;
                    count_d = i_corresp_count;
                    quo_d   = i_sigma_s[0];
                    rem_d   = '0;
                    cyc_d   = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = quo_step;
                rem_d = REM_BW'(q_bit ? (rem_sh - count_ext) : rem_sh);
                if (cyc_q == DIV_LAST) begin
                    cyc_d      = '0;
                    root_start = 1'b1;
                    state_d    = SQRT;
                end else begin
                    cyc_d = cyc_q + CYC_BW'(1);
                end
            end
            SQRT: begin
                if (cyc_q == SQRT_LAST) begin
                    cyc_d   = '0;
                    state_d = WRITE;
                end else begin
                    cyc_d = cyc_q + CYC_BW'(1);
                end
            end
            WRITE: begin
                if (root_done) begin
                    sigma_d[ch_q] = wr_val;
                end
                if (ch_q == CH_LAST) begin
                    fend_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    ch_d    = ch_next;
                    quo_d   = sum_q[ch_next];
                    rem_d   = '0;
                    cyc_d   = '0;
                    state_d = DIV;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cyc_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            sigma_q <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            fend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cyc_q   <= cyc_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            sigma_q <= sigma_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            fend_q  <= fend_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_drop      = drop_q;
    assign o_frame_end = fend_q;
    assign o_sigma     = sigma_q;

endmodule

// File: tb/tb_sigma_rgbd_multi_generator.sv
// Scoreboard bench for sigma_rgbd_multi_generator (NUM_CH=2, DATA_RGB_BW=8); honours SIGMA_RGBD_FLOOR_EN.
module tb_sigma_rgbd_multi_generator;

    localparam int NUM_CH    = 2;
    localparam int SUM_BW    = 38;
    localparam int CNT_BW    = 20;
    localparam int OUT_BW    = 9;
    localparam int ROOT_BW   = 19;
    localparam int MIN_SIGMA = 1;
    localparam int CH_LAT    = SUM_BW + ROOT_BW + 1;
    localparam int FRAME_LAT = NUM_CH * CH_LAT;

    typedef struct {
        logic [OUT_BW-1:0] s0;
        logic [OUT_BW-1:0] s1;
        int                cap;
    } exp_t;

    logic                          clk;
    logic                          rst_n;
    logic                          fe;
    logic [NUM_CH-1:0][SUM_BW-1:0] sums;
    logic [CNT_BW-1:0]             count;
    logic                          o_busy;
    logic                          o_drop;
    logic                          o_frame_end;
    logic [NUM_CH-1:0][OUT_BW-1:0] o_sigma;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_fend  = 0;
    int   n_drop  = 0;
    int   n_acc   = 0;
    bit   prev_fend = 1'b0;
    exp_t sb_q[$];

    sigma_rgbd_multi_generator #(
        .NUM_CH          (NUM_CH),
        .DATA_RGB_BW     (8),
        .MIN_SIGMA       (MIN_SIGMA)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_frame_end     (fe),
        .i_sigma_s       (sums),
        .i_corresp_count (count),
        .o_busy          (o_busy),
        .o_drop          (o_drop),
        .o_frame_end     (o_frame_end),
        .o_sigma         (o_sigma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_BW-1:0] model(input longint unsigned s, input longint unsigned c);
        longint unsigned q, lo, hi, mid;
        q  = (c == 0) ? 64'd0 : s / c;
        lo = 0;
        hi = 64'd1 << 20;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= q) lo = mid;
            else hi = mid - 1;
        end
        if (lo > 511) lo = 511;
`ifdef SIGMA_RGBD_FLOOR_EN
        if (lo < MIN_SIGMA) lo = MIN_SIGMA;
`endif
        return lo[OUT_BW-1:0];
    endfunction

    // Called right after a negedge; frame_end is sampled on the next posedge.
    task automatic send_frame(input logic [SUM_BW-1:0] s0, input logic [SUM_BW-1:0] s1,
                              input logic [CNT_BW-1:0] cnt, input bit accept);
        exp_t e;
        sums  = {s1, s0};
        count = cnt;
        fe    = 1'b1;
        if (accept) begin
            e.s0  = model(s0, cnt);
            e.s1  = model(s1, cnt);
            e.cap = cyc + 1;
            sb_q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        fe = 1'b0;
        $display("[TB] frame_end sums=%0d,%0d count=%0d %s", s0, s1, cnt, accept ? "accepted" : "dropped");
        check_eq(accept ? "no_drop" : "drop", o_drop, accept ? 64'd0 : 64'd1);
        if (accept) check_eq("busy_rise", o_busy, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", sb_q.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prev_fend) check_eq("busy_fall", o_busy, 0);
        if (o_drop) n_drop++;
        if (o_frame_end) begin
            n_fend++;
            check_eq("fend_expected", sb_q.size(), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("[TB] frame_done cycle=%0d sigma=%0d,%0d expected=%0d,%0d",
                         cyc, o_sigma[0], o_sigma[1], e.s0, e.s1);
                check_eq("sigma0", o_sigma[0], e.s0);
                check_eq("sigma1", o_sigma[1], e.s1);
                check_eq("latency", cyc - e.cap, FRAME_LAT);
                check_eq("busy_at_fend", o_busy, 1);
            end
        end
        prev_fend = o_frame_end;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int fend_before;
        logic [SUM_BW-1:0] r0, r1;
        rst_n = 1'b0;
        fe    = 1'b0;
        sums  = '0;
        count = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_drop", o_drop, 0);
        check_eq("rst_fend", o_frame_end, 0);
        check_eq("rst_sigma0", o_sigma[0], 0);
        check_eq("rst_sigma1", o_sigma[1], 0);

        send_frame(38'd1600, 38'd10, 20'd4, 1'b1);
        wait_drain();
        send_frame(38'd10, 38'd99, 20'd3, 1'b1);
        wait_drain();
        send_frame(38'd1000000, {SUM_BW{1'b1}}, 20'd1, 1'b1);
        wait_drain();
        send_frame(38'd123456, 38'd5, 20'd0, 1'b1);
        wait_drain();

        // Overlapping frame_end 10 cycles after capture.
        send_frame(38'd1600, 38'd10, 20'd4, 1'b1);
        repeat (9) @(negedge clk);
        send_frame(38'd99, 38'd99, 20'd1, 1'b0);
        wait_drain();

        // frame_end in the DONE cycle is dropped; the very next cycle is accepted.
        send_frame(38'd10, 38'd99, 20'd3, 1'b1);
        repeat (FRAME_LAT) @(negedge clk);
        send_frame(38'd77, 38'd88, 20'd2, 1'b0);
        send_frame(38'd40000, 38'd2500, 20'd1, 1'b1);
        wait_drain();

        // Reset during channel 1 square root.
        send_frame(38'd1600, 38'd10, 20'd4, 1'b1);
        repeat (CH_LAT + SUM_BW + 5) @(negedge clk);
        check_eq("sigma0_before_rst", o_sigma[0], model(1600, 4));
        check_eq("busy_before_rst", o_busy, 1);
        rst_n = 1'b0;
        sb_q.delete();
        n_acc--;
        #1;
        check_eq("midrst_sigma0", o_sigma[0], 0);
        check_eq("midrst_sigma1", o_sigma[1], 0);
        check_eq("midrst_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fend_before = n_fend;
        repeat (150) @(negedge clk);
        check_eq("no_fend_after_rst", n_fend, fend_before);
        send_frame(38'd1600, 38'd10, 20'd4, 1'b1);
        wait_drain();

        for (int i = 0; i < 4; i++) begin
            r0 = SUM_BW'({$urandom, $urandom});
            r1 = SUM_BW'($urandom_range(0, 100000));
            send_frame(r0, r1, CNT_BW'($urandom_range(0, 5000)), 1'b1);
            wait_drain();
        end

        check_eq("fend_total", n_fend, n_acc);
        check_eq("drop_total", n_drop, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
